vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640: active pixels per line.
REQ-002 SHALL have parameter H_FP, 16: horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96: hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, 48: horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, 480: active lines per frame.
REQ-006 SHALL have parameter V_FP, 10: vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2: vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, 33: vertical back porch in lines.
REQ-009 SHALL have port clk_in, input, 1: the single clock; all state changes on its rising edge.
REQ-010 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-011 SHALL have port pix_tick, input, 1: pixel-rate enable from the clock divider stage.
REQ-012 SHALL have port hsync, output, 1: horizontal sync, active-low.
REQ-013 SHALL have port vsync, output, 1: vertical sync, active-low.
REQ-014 SHALL have port video_on, output, 1: high while the current pixel is in the visible area.
REQ-015 SHALL have port pixel_x, output, HW: current horizontal count, HW = $clog2(H_TOTAL).
REQ-016 SHALL have port pixel_y, output, VW: current vertical count, VW = $clog2(V_TOTAL).
REQ-017 SHALL have port frame_start, output, 1: one-clk_in pulse on the wrap to (0,0).

Function
REQ-018 SHALL define H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
REQ-019 SHALL hold both counters unchanged on any clk_in edge with pix_tick=0.
REQ-020 SHALL, on pix_tick=1, increment pixel_x; at H_TOTAL-1, wrap it to 0 and advance pixel_y.
REQ-021 SHALL wrap pixel_y from V_TOTAL-1 to 0 when pixel_x wraps on that line; pixel_y changes only on a pixel_x wrap.
REQ-022 SHALL register hsync, vsync and video_on so that they correspond to the pixel_x/pixel_y values present in the same cycle, with zero extra latency.
REQ-023 SHALL drive hsync=0 iff H_VISIBLE+H_FP <= pixel_x <= H_VISIBLE+H_FP+H_SYNC-1 (default 656..751).
REQ-024 SHALL drive vsync=0 iff V_VISIBLE+V_FP <= pixel_y <= V_VISIBLE+V_FP+V_SYNC-1 (default 490..491).
REQ-025 SHALL drive video_on=1 iff pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-026 SHALL pulse frame_start high for exactly one clk_in cycle, namely the cycle in which the counters first read (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1); it SHALL NOT pulse on reset release.
REQ-027 SHALL advance on every cycle when pix_tick is held high continuously; there is no back-pressure.

Reset
REQ-028 SHALL give rst priority over pix_tick when both are high on the same edge.
REQ-029 SHALL, on reset, set pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, frame_start=0, frame_cnt=0.
REQ-030 SHALL, on reset asserted mid-frame, abandon the frame and resume from (0,0) on the first pix_tick after rst deasserts.

Configuration
REQ-031 SHALL, with macro VGA_FRAME_CNT_EN defined, add output port frame_cnt (8 bits) that increments on each frame_start, wraps from 255 to 0, and resets to 0.
REQ-032 SHALL, without VGA_FRAME_CNT_EN, omit the frame_cnt port and its register entirely; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover: rst=1 then released, pix_tick=0 for 10 cycles -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, frame_start=0 throughout.
REQ-034 SHALL cover: pix_tick=1 every cycle for one line -> video_on falls at pixel_x=640; hsync low for exactly 96 ticks (656..751); at 799 pixel_x wraps to 0 and pixel_y=1.
REQ-035 SHALL cover: pix_tick=1 for a full frame (420000 ticks) -> vsync low for exactly 2 lines (y=490,491); frame_start pulses once at the return to (0,0); frame_cnt=1 with VGA_FRAME_CNT_EN.
REQ-036 SHALL cover: pix_tick asserted once every 4 cycles -> counters step only on tick edges; all outputs stay stable between ticks.
REQ-037 SHALL cover: rst=1 and pix_tick=1 together at (300,200) -> next cycle (0,0) with reset values and no frame_start.
REQ-038 SHALL cover: 256 full frames with VGA_FRAME_CNT_EN -> frame_cnt wraps 255->0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator.
//
// Walks a pixel counter (pixel_x) and a line counter (pixel_y) through one
// full frame (visible area, front porch, sync, back porch). The counters
// advance only on clock edges where pix_tick is high. hsync, vsync and
// video_on are registered and are decoded from the next counter values.
// As a result, they always describe the pixel_x/pixel_y pair visible in
// the same cycle.
//
// Optional feature: define VGA_FRAME_CNT_EN to add an 8-bit frame counter
// output (frame_cnt) that counts frame_start pulses and wraps 255 -> 0.
//
// Ports:
//   clk_in      - single clock, all state changes on rising edge
//   rst         - synchronous, active-high reset (priority over pix_tick)
//   pix_tick    - pixel-rate enable
//   hsync       - horizontal sync, active-low
//   vsync       - vertical sync, active-low
//   video_on    - high while (pixel_x, pixel_y) is inside the visible area
//   pixel_x     - horizontal count, 0 .. H_TOTAL-1
//   pixel_y     - vertical count, 0 .. V_TOTAL-1
//   frame_start - one-cycle pulse when the counters wrap back to (0,0)
//   frame_cnt   - (VGA_FRAME_CNT_EN only) frames completed, modulo 256

module vga_sync_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
   localparam int unsigned HW       = $clog2(H_TOTAL),
   localparam int unsigned VW       = $clog2(V_TOTAL)
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          pix_tick,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [HW-1:0] pixel_x,
   output logic [VW-1:0] pixel_y,
   output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0]    frame_cnt
`endif
);

   // Timing boundaries, sized to the counter widths
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_VISIBLE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_VISIBLE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [HW-1:0] x_q, x_d;
   logic [VW-1:0] y_q, y_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;
   logic          frame_start_q;
   logic          frame_wrap;

   // Counter next-state
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      frame_wrap = 1'b0;
      if (pix_tick) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
               y_d        = '0;
               frame_wrap = 1'b1;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Decode from the next counter values so the registered syncs line up
   // with the registered counters in the same cycle.
   always_comb begin
      hsync_d    = ~((x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vsync_d    = ~((y_d >= VS_FIRST) && (y_d <= VS_LAST));
      video_on_d = (x_d < H_VIS_END) && (y_d < V_VIS_END);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         // High only in the first cycle at (0,0); later idle cycles clear it
         frame_start_q <= frame_wrap;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         frame_cnt_q <= 8'd0;
      end else if (frame_wrap) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized self-checking bench for vga_sync_gen.
// Two instances share rst/pix_tick: one with the default 640x480 timing,
// and one with a scaled-down geometry so that whole frames (and 256 of them
// with VGA_FRAME_CNT_EN) fit in a short run. The reference model tracks a
// linear position within the frame and derives x/y/syncs arithmetically.

module tb_vga_sync_gen;

   // Small geometry: 16 x 12 total, 192 ticks per frame
   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
   localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 3;
   localparam int SHT = 16, SVT = 12, SFT = SHT * SVT;
   // Default geometry
   localparam int BHV = 640, BHF = 16, BHS = 96, BHB = 48;
   localparam int BVV = 480, BVF = 10, BVS = 2, BVB = 33;
   localparam int BHT = 800, BVT = 525, BFT = BHT * BVT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   always #5 clk = ~clk;

   logic       s_hs, s_vs, s_vo, s_fs;
   logic [3:0] s_x, s_y;
   logic       b_hs, b_vs, b_vo, b_fs;
   logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] s_fc, b_fc;
`endif

   vga_sync_gen #(
      .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) u_small (
      .clk_in(clk), .rst(rst), .pix_tick(tick),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
      .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(s_fc)
`endif
   );

   vga_sync_gen #(
      .H_VISIBLE(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
      .V_VISIBLE(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
   ) u_big (
      .clk_in(clk), .rst(rst), .pix_tick(tick),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
      .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(b_fc)
`endif
   );

   // Reference model: linear position inside the frame
   int         ps, pb;
   logic       fss, fsb;
   logic [7:0] fcs, fcb;

   always @(posedge clk) begin
      if (rst) begin
         ps <= 0; pb <= 0; fss <= 1'b0; fsb <= 1'b0; fcs <= 8'd0; fcb <= 8'd0;
      end else if (tick) begin
         ps  <= (ps + 1) % SFT;
         pb  <= (pb + 1) % BFT;
         fss <= (ps + 1 == SFT);
         fsb <= (pb + 1 == BFT);
         if (ps + 1 == SFT) fcs <= fcs + 8'd1;
         if (pb + 1 == BFT) fcb <= fcb + 8'd1;
      end else begin
         fss <= 1'b0;
         fsb <= 1'b0;
      end
   end

   // {hsync, vsync, video_on} for a linear position
   function automatic logic [2:0] sync_flags(int p, int hv, int hf, int hs, int ht,
                                             int vv, int vf, int vs);
      int x = p % ht;
      int y = p / ht;
      sync_flags[2] = !(x >= hv + hf && x < hv + hf + hs);
      sync_flags[1] = !(y >= vv + vf && y < vv + vf + vs);
      sync_flags[0] = (x < hv) && (y < vv);
   endfunction

   logic [11:0] s_act, s_exp;
   logic [23:0] b_act, b_exp;
   assign s_act = {s_hs, s_vs, s_vo, s_fs, s_x, s_y};
   assign b_act = {b_hs, b_vs, b_vo, b_fs, b_x, b_y};
   always_comb begin
      s_exp = {sync_flags(ps, SHV, SHF, SHS, SHT, SVV, SVF, SVS), fss,
               4'(ps % SHT), 4'(ps / SHT)};
      b_exp = {sync_flags(pb, BHV, BHF, BHS, BHT, BVV, BVF, BVS), fsb,
               10'(pb % BHT), 10'(pb / BHT)};
   end

   localparam logic [11:0] S_RST = 12'hE00;
   localparam logic [23:0] B_RST = 24'hE00000;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic do_reset();
      rst = 1'b1;
      tick = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tick = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests_run++;
         if (s_act !== S_RST || b_act !== B_RST) begin
            tests_failed++;
            $display("FAIL reset_idle cyc=%0d small=%h want %h big=%h want %h",
                     i, s_act, S_RST, b_act, B_RST);
         end
`ifdef VGA_FRAME_CNT_EN
         tests_run++;
         if (s_fc !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_frame_cnt got=%0d want 0", s_fc);
         end
`endif
      end
   endtask

   task automatic test_line();
      int hs_low = 0;
      int fall_x = -1;
      do_reset();
      tick = 1'b1;
      for (int i = 0; i < BHT; i++) begin
         @(negedge clk);
         tests_run++;
         if (b_act !== b_exp) begin
            tests_failed++;
            $display("FAIL line_track cyc=%0d got=%h want %h", i, b_act, b_exp);
         end
         if (b_hs == 1'b0) hs_low++;
         if (b_vo == 1'b0 && fall_x < 0) fall_x = int'(b_x);
      end
      tick = 1'b0;
      tests_run++;
      if (hs_low != BHS) begin
         tests_failed++;
         $display("FAIL line_hsync_width got=%0d want %0d", hs_low, BHS);
      end
      tests_run++;
      if (fall_x != BHV) begin
         tests_failed++;
         $display("FAIL line_video_fall got x=%0d want %0d", fall_x, BHV);
      end
      tests_run++;
      if (b_x !== 10'd0 || b_y !== 10'd1) begin
         tests_failed++;
         $display("FAIL line_wrap got (%0d,%0d) want (0,1)", b_x, b_y);
      end
   endtask

   task automatic test_frame();
      int vs_low = 0;
      int fs_cnt = 0;
      do_reset();
      tick = 1'b1;
      for (int i = 0; i < SFT; i++) begin
         @(negedge clk);
         tests_run++;
         if (s_act !== s_exp) begin
            tests_failed++;
            $display("FAIL frame_track cyc=%0d got=%h want %h", i, s_act, s_exp);
         end
         if (s_vs == 1'b0) vs_low++;
         if (s_fs == 1'b1) fs_cnt++;
      end
      tick = 1'b0;
      tests_run++;
      if (vs_low != SVS * SHT) begin
         tests_failed++;
         $display("FAIL frame_vsync_width got=%0d want %0d", vs_low, SVS * SHT);
      end
      tests_run++;
      if (fs_cnt != 1 || s_x !== 4'd0 || s_y !== 4'd0) begin
         tests_failed++;
         $display("FAIL frame_start_once got pulses=%0d at (%0d,%0d) want 1 at (0,0)",
                  fs_cnt, s_x, s_y);
      end
`ifdef VGA_FRAME_CNT_EN
      tests_run++;
      if (s_fc !== 8'd1) begin
         tests_failed++;
         $display("FAIL frame_cnt_one got=%0d want 1", s_fc);
      end
`endif
   endtask

   // One tick every 4 cycles, long enough to cross a frame wrap
   task automatic test_sparse_tick();
      for (int i = 0; i < 4 * (SFT + 8); i++) begin
         tick = (i % 4 == 0);
         @(negedge clk);
         tests_run++;
         if (s_act !== s_exp || b_act !== b_exp) begin
            tests_failed++;
            $display("FAIL sparse_track cyc=%0d small=%h want %h big=%h want %h",
                     i, s_act, s_exp, b_act, b_exp);
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         tick = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 199) == 0);
         @(negedge clk);
         tests_run++;
         if (s_act !== s_exp || b_act !== b_exp) begin
            tests_failed++;
            $display("FAIL random_track cyc=%0d small=%h want %h big=%h want %h",
                     i, s_act, s_exp, b_act, b_exp);
         end
      end
      rst = 1'b0;
      tick = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick = 1'b1;
      repeat (5 * SHT + 9) @(negedge clk);
      rst = 1'b1;   // together with tick: reset wins
      @(negedge clk);
      tests_run++;
      if (s_act !== S_RST || b_act !== B_RST) begin
         tests_failed++;
         $display("FAIL reset_mid small=%h want %h big=%h want %h", s_act, S_RST, b_act, B_RST);
      end
      rst = 1'b0;
      tick = 1'b0;
      @(negedge clk);
      tests_run++;
      if (s_act !== S_RST || b_act !== B_RST) begin
         tests_failed++;
         $display("FAIL reset_mid_hold small=%h want %h big=%h want %h",
                  s_act, S_RST, b_act, B_RST);
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      tests_run++;
      if (s_x !== 4'd1 || s_y !== 4'd0 || b_x !== 10'd1 || b_y !== 10'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_resume small=(%0d,%0d) big=(%0d,%0d) want (1,0)",
                  s_x, s_y, b_x, b_y);
      end
   endtask

`ifdef VGA_FRAME_CNT_EN
   task automatic test_back_to_back();
      do_reset();
      tick = 1'b1;
      for (int f = 1; f <= 256; f++) begin
         for (int i = 0; i < SFT; i++) begin
            @(negedge clk);
            tests_run++;
            if (s_act !== s_exp) begin
               tests_failed++;
               $display("FAIL b2b_track frame=%0d got=%h want %h", f, s_act, s_exp);
            end
         end
         tests_run++;
         if (s_fc !== 8'(f)) begin
            tests_failed++;
            $display("FAIL b2b_frame_cnt frame=%0d got=%0d want %0d", f, s_fc, 8'(f));
         end
      end
      tick = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_sparse_tick();
      test_random();
      test_reset_mid();
`ifdef VGA_FRAME_CNT_EN
      test_back_to_back();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
